// File: rtl/serial_subtractor64.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// computed as a + ~b + 1 with the carry register preset to 1.
module serial_subtractor64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-2:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             nb;
   logic             sum_bit;
   logic             carry_out;
   logic             last;

   always_comb begin
      nb        = ~op_b[0];
      sum_bit   = op_a[0] ^ nb ^ carry;
      carry_out = (op_a[0] & nb) | (op_a[0] & carry) | (nb & carry);
      last      = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_a     <= '0;
         op_b     <= '0;
         res      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         borrow   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= 1'b1;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               // res is one bit short of WIDTH; the final sum bit goes straight into diff.
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               res   <= (WIDTH-1)'({sum_bit, res} >> 1);
               carry <= carry_out;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  diff     <= {sum_bit, res};
                  borrow   <= ~carry_out;
                  overflow <= carry ^ carry_out;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor64.sv
// Bench for serial_subtractor64: a cycle-level behavioural model of the
// operation timing and plain a-b arithmetic, plus directed literal cases.
module tb_serial_subtractor64;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        armed = 1'b0;

   serial_subtractor64 #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .borrow   (borrow),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Model: an accepted request completes exactly W edges later with a-b.
   int           rem      = 0;
   logic [W-1:0] p_diff   = '0;
   logic         p_borrow = 1'b0;
   logic         p_ovf    = 1'b0;
   logic         m_busy   = 1'b0;
   logic         m_done   = 1'b0;
   logic [W-1:0] m_diff   = '0;
   logic         m_borrow = 1'b0;
   logic         m_ovf    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         rem = 0; m_busy = 0; m_done = 0; m_diff = '0; m_borrow = 0; m_ovf = 0;
      end else if (rem > 0) begin
         rem = rem - 1;
         if (rem == 0) begin
            m_busy = 0; m_done = 1;
            m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf;
         end
      end else if (start) begin
         p_diff   = a - b;
         p_borrow = (a < b);
         p_ovf    = (a[W-1] != b[W-1]) && (p_diff[W-1] != a[W-1]);
         rem      = W;
         m_busy   = 1;
         m_done   = 0;
      end else begin
         m_done = 0;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("diff", diff, m_diff);
         check("borrow", borrow, m_borrow);
         check("overflow", overflow, m_ovf);
      end
   end

   // Caller is just after a rising edge; returns just after the done edge.
   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
      int n;
      int bn;
      a = ta; b = tb_; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n  = 0;
      bn = busy ? 1 : 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (busy) bn++;
      end
      check({nm, "_latency"}, n, W);
      check({nm, "_busy_cycles"}, bn, W);
      check({nm, "_diff"}, diff, ed);
      check({nm, "_borrow"}, borrow, eb);
      check({nm, "_overflow"}, overflow, eo);
      check({nm, "_model_diff"}, m_diff, ed);
      check({nm, "_model_flags"}, {m_borrow, m_ovf}, {eb, eo});
   endtask

   initial begin
      int n;
      int nd;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      armed = 1'b1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_flags", {borrow, overflow}, 0);

      @(posedge clk); #1;
      run_op("sub_5_3", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0);
      @(posedge clk); #1;
      run_op("sub_0_1", 64'd0, 64'd1, '1, 1'b1, 1'b0);
      @(posedge clk); #1;
      run_op("min_minus_1", 64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
      @(posedge clk); #1;
      run_op("max_minus_neg1", 64'h7FFF_FFFF_FFFF_FFFF, '1,
             64'h8000_0000_0000_0000, 1'b1, 1'b1);
      // start raised in the DONE cycle itself
      run_op("back_to_back", 64'd100, 64'd250, 64'hFFFF_FFFF_FFFF_FF6A, 1'b1, 1'b0);

      // A second start mid-operation must be ignored.
      @(posedge clk); #1;
      a = 64'd10; b = 64'd4; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      repeat (19) begin @(posedge clk); #1; n++; end
      a = 64'd1; b = 64'd2; start = 1'b1;
      @(posedge clk); #1 start = 1'b0; n++;
      while (!done && n < 200) begin @(posedge clk); #1; n++; end
      check("ignored_latency", n, W);
      check("ignored_diff", diff, 64'd6);
      check("ignored_borrow", borrow, 0);
      nd = 0;
      repeat (80) begin @(posedge clk); #1; if (done) nd++; end
      check("ignored_no_second_done", nd, 0);

      // Reset 30 cycles into an operation aborts it.
      a = '1; b = 64'd1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      nd = 0;
      repeat (100) begin @(posedge clk); #1; if (done) nd++; end
      check("abort_no_done", nd, 0);
      run_op("after_reset", 64'd17, 64'd5, 64'd12, 1'b0, 1'b0);

      // Random traffic, including starts during RUN and in the DONE cycle.
      nd = 0;
      repeat (1500) begin
         @(posedge clk); #1;
         if (done) nd++;
         start = ($urandom_range(0, 7) == 0);
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 9) == 0) ? a : {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) a[W-1] = ~a[W-1];
      end
      start = 1'b0;
      check("random_had_dones", (nd > 10) ? 1 : 0, 1);
      repeat (80) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
